// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and frame field widths.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         LEN_W         = 16;
  localparam int         CHK_W         = 8;

  // States in which the inter-byte gap counter runs.
  function automatic logic in_frame(input state_t s);
    return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into big-endian 32-bit words and keeps a running XOR of the packed bytes.
module byte_packer
  import loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             strobe,
  input  logic             clear,
  output logic [31:0]      word,
  output logic             word_valid,
  output logic [CHK_W-1:0] xor_acc
);

  logic [1:0]  cnt_p0;
  logic [23:0] shift_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p0  <= 2'd0;
      xor_acc <= '0;
    end else if (clear) begin
      cnt_p0  <= 2'd0;
      xor_acc <= '0;
    end else if (strobe) begin
      cnt_p0  <= cnt_p0 + 2'd1;
      xor_acc <= xor_acc ^ byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (strobe) shift_p0 <= {shift_p0[15:0], byte_in};
  end

  // Word is presented in the same cycle as its fourth byte; the top registers it.
  assign word       = {shift_p0, byte_in};
  assign word_valid = strobe && (cnt_p0 == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes instruction memory and releases the CPU on a good checksum.
module imem_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter int         BASE_ADDR = 0,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int                GAP_W   = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W:0]    MAX_LEN = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  state_t             state_q, state_nx;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_full;
  logic [GAP_W-1:0]   gap_q;
  logic               fire, timeout, last_word;
  logic               start_frame, data_stb, enter_done, enter_err;
  logic [31:0]        word;
  logic               word_valid;
  logic [CHK_W-1:0]   xor_acc;

  assign fire      = in_valid && in_ready;
  assign timeout   = in_frame(state_q) && (gap_q == GAP_W'(TIMEOUT));
  assign len_full  = {len_q[LEN_W-1:8], in_data};
  assign last_word = (32'(words_loaded) + 32'd1) == 32'(len_q);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (in_data),
    .strobe     (data_stb),
    .clear      (start_frame),
    .word       (word),
    .word_valid (word_valid),
    .xor_acc    (xor_acc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR:
        if (fire && in_data == SYNC_BYTE) state_nx = ST_LEN_HI;
      ST_LEN_HI:
        if (fire) state_nx = ST_LEN_LO;
      ST_LEN_LO:
        if (fire) begin
          if ({1'b0, len_full} > MAX_LEN) state_nx = ST_ERROR;
          else if (len_full == '0)        state_nx = ST_CHECK;
          else                            state_nx = ST_DATA;
        end
      ST_DATA:
        if (word_valid && last_word) state_nx = ST_CHECK;
      ST_CHECK:
        if (fire) state_nx = (in_data == xor_acc) ? ST_DONE : ST_ERROR;
      default:
        state_nx = ST_IDLE;
    endcase
    if (timeout) state_nx = ST_ERROR;
  end

  always_comb begin
    start_frame = 1'b0;
    data_stb    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: start_frame = fire && (in_data == SYNC_BYTE);
      ST_DATA:                    data_stb    = fire && !timeout;
      default:                    ;
    endcase
    enter_done = (state_nx == ST_DONE)  && (state_q != ST_DONE);
    enter_err  = (state_nx == ST_ERROR) && (state_q != ST_ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q <= '0;
      len_q <= '0;
    end else begin
      if (fire || !in_frame(state_q)) gap_q <= '0;
      else                            gap_q <= gap_q + GAP_W'(1);
      if (fire && state_q == ST_LEN_HI) len_q <= {in_data, len_q[7:0]};
      if (fire && state_q == ST_LEN_LO) len_q <= len_full;
    end
  end

  // Write port: one registered strobe per completed word; address/data hold afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      mem_we   <= word_valid;
      if (word_valid) begin
        mem_addr     <= BASE + words_loaded[ADDR_W-1:0];
        mem_wdata    <= word;
        words_loaded <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
      end
      if (start_frame) begin
        words_loaded <= '0;
        load_done    <= 1'b0;
        load_err     <= 1'b0;
        cpu_hold     <= 1'b1;
      end else if (enter_done) begin
        load_done <= 1'b1;
        cpu_hold  <= 1'b0;
      end else if (enter_err) begin
        load_err <= 1'b1;
        cpu_hold <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, empty frame, oversize length, timeout, mid-frame reset.
module tb_imem_loader;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 20;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int          we_cnt = 0;
  int          errs = 0;
  int          checks = 0;
  int          we_base;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (0),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt        <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input bq_t q, input int maxgap);
    foreach (q[i]) send(q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;

    // Reset state
    idle(3);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Good two-word frame; checksum is XOR of the eight data bytes = 8D
    send(8'h33, 0);
    we_base = we_cnt;
    send_seq('{8'hA5, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
               8'hAC, 8'h08, 8'h00, 8'h00, 8'h8D}, 0);
    idle(2);
    chk("t1_we_count", 32'(we_cnt - we_base), 32'd2);
    chk("t1_mem0", mem[0], 32'h24080005);
    chk("t1_mem1", mem[1], 32'hAC080000);
    chk("t1_done", 32'(load_done), 32'd1);
    chk("t1_hold", 32'(cpu_hold), 32'd0);
    chk("t1_err", 32'(load_err), 32'd0);
    chk("t1_words", 32'(words_loaded), 32'd2);
    chk("t1_addr_hold", 32'(mem_addr), 32'd1);
    chk("t1_wdata_hold", mem_wdata, 32'hAC080000);

    // Same frame, bad checksum
    mem[0] = 32'h0;
    mem[1] = 32'h0;
    we_base = we_cnt;
    send_seq('{8'hA5, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
               8'hAC, 8'h08, 8'h00, 8'h00, 8'h00}, 0);
    idle(2);
    chk("t2_we_count", 32'(we_cnt - we_base), 32'd2);
    chk("t2_mem1", mem[1], 32'hAC080000);
    chk("t2_err", 32'(load_err), 32'd1);
    chk("t2_hold", 32'(cpu_hold), 32'd1);
    chk("t2_done", 32'(load_done), 32'd0);

    // Empty frame
    we_base = we_cnt;
    send_seq('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
    idle(2);
    chk("t3_we_count", 32'(we_cnt - we_base), 32'd0);
    chk("t3_done", 32'(load_done), 32'd1);
    chk("t3_err", 32'(load_err), 32'd0);
    chk("t3_hold", 32'(cpu_hold), 32'd0);
    chk("t3_words", 32'(words_loaded), 32'd0);

    // Oversize length 0x0401 > 1024 words: error straight after LEN_LO, trailing bytes ignored
    we_base = we_cnt;
    send_seq('{8'hA5, 8'h04, 8'h01}, 0);
    chk("t4_err_now", 32'(load_err), 32'd1);
    chk("t4_hold", 32'(cpu_hold), 32'd1);
    send_seq('{8'h11, 8'h22, 8'h33, 8'h44, 8'h00}, 0);
    idle(2);
    chk("t4_we_count", 32'(we_cnt - we_base), 32'd0);
    chk("t4_err_kept", 32'(load_err), 32'd1);
    chk("t4_done", 32'(load_done), 32'd0);

    // Stall after the second data byte until the gap counter expires
    we_base = we_cnt;
    send_seq('{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22}, 0);
    idle(TIMEOUT + 5);
    chk("t5_err", 32'(load_err), 32'd1);
    chk("t5_hold", 32'(cpu_hold), 32'd1);
    chk("t5_we_count", 32'(we_cnt - we_base), 32'd0);
    // Follow-up frame with an in-frame gap shorter than the timeout
    we_base = we_cnt;
    send_seq('{8'hA5, 8'h00, 8'h01, 8'hDE}, 0);
    send(8'hAD, TIMEOUT - 6);
    send_seq('{8'hBE, 8'hEF, 8'h22}, 0);
    idle(2);
    chk("t5b_we_count", 32'(we_cnt - we_base), 32'd1);
    chk("t5b_mem0", mem[0], 32'hDEADBEEF);
    chk("t5b_done", 32'(load_done), 32'd1);
    chk("t5b_err", 32'(load_err), 32'd0);
    chk("t5b_words", 32'(words_loaded), 32'd1);

    // Reset asserted after five data bytes of a two-word frame
    send_seq('{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_rst_we", 32'(mem_we), 32'd0);
    chk("t6_rst_addr", 32'(mem_addr), 32'd0);
    chk("t6_rst_wdata", mem_wdata, 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    chk("t6_rst_hold", 32'(cpu_hold), 32'd1);
    chk("t6_rst_done", 32'(load_done), 32'd0);
    chk("t6_rst_err", 32'(load_err), 32'd0);
    chk("t6_rst_words", 32'(words_loaded), 32'd0);
    chk("t6_partial_mem0", mem[0], 32'h01020304);
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    // Fresh frame with random valid gaps and an in-frame SYNC value; checksum = 91
    we_base = we_cnt;
    send_seq('{8'hA5, 8'h00, 8'h02, 8'h12, 8'hA5, 8'h56, 8'h78,
               8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h91}, 3);
    idle(2);
    chk("t6_we_count", 32'(we_cnt - we_base), 32'd2);
    chk("t6_mem0", mem[0], 32'h12A55678);
    chk("t6_mem1", mem[1], 32'h9ABCDEF0);
    chk("t6_done", 32'(load_done), 32'd1);
    chk("t6_hold", 32'(cpu_hold), 32'd0);
    chk("t6_words", 32'(words_loaded), 32'd2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
